// File: rtl/dispatch.sv
// Dispatch stage: 2-slot in-order buffer behind rename that writes the ROB and steers to the ALU/MDU/LSU RS.
// Optional performance counters are enabled with `define DISPATCH_PERF_EN.
package dispatch_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef struct packed {
        logic       is_valid;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [5:0] dest_tag;
    } instruction_t;
endpackage

module dispatch
    import dispatch_pkg::*;
#(
    parameter int PERF_CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         rename_val,
    input  instruction_t renamed_inst0,
    input  instruction_t renamed_inst1,
    output logic         dispatch_rdy,
    output logic [1:0]   rob_we,
    output instruction_t rob_entry0,
    output instruction_t rob_entry1,
    input  logic [1:0]   alu_free,
    input  logic [1:0]   mdu_free,
    input  logic [1:0]   lsu_free,
    output logic [1:0]   alu_we,
    output instruction_t alu_inst0,
    output instruction_t alu_inst1,
    output logic [1:0]   mdu_we,
    output instruction_t mdu_inst0,
    output instruction_t mdu_inst1,
    output logic [1:0]   lsu_we,
    output instruction_t lsu_inst0,
    output instruction_t lsu_inst1
`ifdef DISPATCH_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_disp_cnt,
    output logic [PERF_CNT_W-1:0] perf_stall_rs_cnt,
    output logic [PERF_CNT_W-1:0] perf_partial_cnt
`endif
);

    typedef enum logic [1:0] {CLS_ALU, CLS_MDU, CLS_LSU} cls_t;

    function automatic cls_t classify(input instruction_t inst);
        if (inst.opcode == OPC_LOAD || inst.opcode == OPC_STORE)
            return CLS_LSU;
        else if (inst.opcode == OPC_OP && inst.funct7 == F7_MULDIV)
            return CLS_MDU;
        else
            return CLS_ALU;
    endfunction

    function automatic logic [1:0] free_of(input cls_t c, input logic [1:0] a,
                                           input logic [1:0] m, input logic [1:0] l);
        case (c)
            CLS_MDU: return m;
            CLS_LSU: return l;
            default: return a;
        endcase
    endfunction

    instruction_t slot0_p0, slot1_p0;
    cls_t         cls0, cls1;
    logic         live, d0, d1, drain;
    logic [1:0]   need1;

    // ---- stage p0 -> decision: combinational from the registered slots ----
    always_comb begin
        live  = !rst && !flush;
        cls0  = classify(slot0_p0);
        cls1  = classify(slot1_p0);
        need1 = (cls1 == cls0) ? 2'd2 : 2'd1;
        d0    = live && slot0_p0.is_valid && (free_of(cls0, alu_free, mdu_free, lsu_free) >= 2'd1);
        d1    = d0 && slot1_p0.is_valid && (free_of(cls1, alu_free, mdu_free, lsu_free) >= need1);
        drain = !slot0_p0.is_valid || (d0 && (d1 || !slot1_p0.is_valid));
        dispatch_rdy = live && drain;
    end

    always_comb begin
        rob_we     = {d1, d0};
        rob_entry0 = d0 ? slot0_p0 : '0;
        rob_entry1 = d1 ? slot1_p0 : '0;
        alu_we = 2'b00; alu_inst0 = '0; alu_inst1 = '0;
        mdu_we = 2'b00; mdu_inst0 = '0; mdu_inst1 = '0;
        lsu_we = 2'b00; lsu_inst0 = '0; lsu_inst1 = '0;
        if (d0) begin
            case (cls0)
                CLS_MDU: begin mdu_we[0] = 1'b1; mdu_inst0 = slot0_p0; end
                CLS_LSU: begin lsu_we[0] = 1'b1; lsu_inst0 = slot0_p0; end
                default: begin alu_we[0] = 1'b1; alu_inst0 = slot0_p0; end
            endcase
        end
        // Younger takes port 1 only when it shares the older one's RS.
        if (d1) begin
            if (cls1 == cls0) begin
                case (cls1)
                    CLS_MDU: begin mdu_we[1] = 1'b1; mdu_inst1 = slot1_p0; end
                    CLS_LSU: begin lsu_we[1] = 1'b1; lsu_inst1 = slot1_p0; end
                    default: begin alu_we[1] = 1'b1; alu_inst1 = slot1_p0; end
                endcase
            end else begin
                case (cls1)
                    CLS_MDU: begin mdu_we[0] = 1'b1; mdu_inst0 = slot1_p0; end
                    CLS_LSU: begin lsu_we[0] = 1'b1; lsu_inst0 = slot1_p0; end
                    default: begin alu_we[0] = 1'b1; alu_inst0 = slot1_p0; end
                endcase
            end
        end
    end

    // ---- buffer update -> slots p0 ----
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            slot0_p0 <= '0;
            slot1_p0 <= '0;
        end else if (drain) begin
            if (rename_val && renamed_inst0.is_valid) begin
                slot0_p0 <= renamed_inst0;
                slot1_p0 <= renamed_inst1.is_valid ? renamed_inst1 : '0;
            end else if (rename_val && renamed_inst1.is_valid) begin
                slot0_p0 <= renamed_inst1;
                slot1_p0 <= '0;
            end else begin
                slot0_p0 <= '0;
                slot1_p0 <= '0;
            end
        end else if (d0) begin
            slot0_p0 <= slot1_p0;
            slot1_p0 <= '0;
        end
    end

`ifdef DISPATCH_PERF_EN
    // Counters survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_disp_cnt     <= '0;
            perf_stall_rs_cnt <= '0;
            perf_partial_cnt  <= '0;
        end else begin
            perf_disp_cnt <= perf_disp_cnt + PERF_CNT_W'(rob_we[0]) + PERF_CNT_W'(rob_we[1]);
            if (!flush && slot0_p0.is_valid && !d0)
                perf_stall_rs_cnt <= perf_stall_rs_cnt + 1'b1;
            if (d0 && slot1_p0.is_valid && !d1)
                perf_partial_cnt <= perf_partial_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dispatch.sv
// Directed self-checking bench for the dispatch stage.
module tb_dispatch;
    import dispatch_pkg::*;

    logic         clk = 1'b0;
    logic         rst, flush, rename_val;
    instruction_t renamed_inst0, renamed_inst1;
    logic         dispatch_rdy;
    logic [1:0]   rob_we, alu_free, mdu_free, lsu_free, alu_we, mdu_we, lsu_we;
    instruction_t rob_entry0, rob_entry1, alu_inst0, alu_inst1;
    instruction_t mdu_inst0, mdu_inst1, lsu_inst0, lsu_inst1;
`ifdef DISPATCH_PERF_EN
    logic [31:0]  perf_disp_cnt, perf_stall_rs_cnt, perf_partial_cnt;
    logic [31:0]  pd0, ps0, pp0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dispatch dut (
        .clk(clk), .rst(rst), .flush(flush), .rename_val(rename_val),
        .renamed_inst0(renamed_inst0), .renamed_inst1(renamed_inst1),
        .dispatch_rdy(dispatch_rdy), .rob_we(rob_we),
        .rob_entry0(rob_entry0), .rob_entry1(rob_entry1),
        .alu_free(alu_free), .mdu_free(mdu_free), .lsu_free(lsu_free),
        .alu_we(alu_we), .alu_inst0(alu_inst0), .alu_inst1(alu_inst1),
        .mdu_we(mdu_we), .mdu_inst0(mdu_inst0), .mdu_inst1(mdu_inst1),
        .lsu_we(lsu_we), .lsu_inst0(lsu_inst0), .lsu_inst1(lsu_inst1)
`ifdef DISPATCH_PERF_EN
        , .perf_disp_cnt(perf_disp_cnt), .perf_stall_rs_cnt(perf_stall_rs_cnt),
        .perf_partial_cnt(perf_partial_cnt)
`endif
    );

    function automatic instruction_t mk(input logic [6:0] op, input logic [6:0] f7,
                                        input logic [5:0] tag);
        instruction_t i;
        i = '0;
        i.is_valid = 1'b1;
        i.opcode   = op;
        i.funct7   = f7;
        i.rd       = 5'(tag + 6'd1);
        i.dest_tag = tag;
        return i;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs/outputs are then handled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input instruction_t a, input instruction_t b);
        rename_val = 1'b1; renamed_inst0 = a; renamed_inst1 = b;
        tick();
        rename_val = 1'b0; renamed_inst0 = '0; renamed_inst1 = '0;
        #1;
    endtask

    instruction_t ADD, SUB, LW, SW, MUL;

    initial begin
        rst = 1'b1; flush = 1'b0; rename_val = 1'b0;
        renamed_inst0 = '0; renamed_inst1 = '0;
        alu_free = 2'd2; mdu_free = 2'd2; lsu_free = 2'd2;
        tick(); tick();
        check("rdy_in_rst", 32'(dispatch_rdy), 0);
        check("robwe_in_rst", 32'(rob_we), 0);
        rst = 1'b0; #1;
        check("rdy_after_rst", 32'(dispatch_rdy), 1);
        check("robwe_after_rst", 32'(rob_we), 0);

        // Mixed ALU + LSU pair, plenty of room
        load(mk(OPC_OP, 7'd0, 6'd3), mk(OPC_LOAD, 7'd0, 6'd4));
        check("s1_rob_we", 32'(rob_we), 2'b11);
        check("s1_alu_we", 32'(alu_we), 2'b01);
        check("s1_lsu_we", 32'(lsu_we), 2'b01);
        check("s1_mdu_we", 32'(mdu_we), 2'b00);
        check("s1_alu_tag", 32'(alu_inst0.dest_tag), 3);
        check("s1_lsu_tag", 32'(lsu_inst0.dest_tag), 4);
        check("s1_rob1_tag", 32'(rob_entry1.dest_tag), 4);
        check("s1_rdy", 32'(dispatch_rdy), 1);
        tick();
        check("s1_empty", 32'(rob_we), 0);

        // MUL pair with a single MDU slot
        mdu_free = 2'd1;
`ifdef DISPATCH_PERF_EN
        pd0 = perf_disp_cnt; ps0 = perf_stall_rs_cnt; pp0 = perf_partial_cnt;
`endif
        load(mk(OPC_OP, F7_MULDIV, 6'd5), mk(OPC_OP, F7_MULDIV, 6'd6));
        check("s2a_rob_we", 32'(rob_we), 2'b01);
        check("s2a_mdu_we", 32'(mdu_we), 2'b01);
        check("s2a_mdu_tag", 32'(mdu_inst0.dest_tag), 5);
        check("s2a_rdy", 32'(dispatch_rdy), 0);
        tick();
        check("s2b_rob_we", 32'(rob_we), 2'b01);
        check("s2b_mdu_we", 32'(mdu_we), 2'b01);
        check("s2b_mdu_tag", 32'(mdu_inst0.dest_tag), 6);
        check("s2b_rob0_tag", 32'(rob_entry0.dest_tag), 6);
        check("s2b_rdy", 32'(dispatch_rdy), 1);
        tick();
`ifdef DISPATCH_PERF_EN
        check("perf_disp", perf_disp_cnt - pd0, 2);
        check("perf_partial", perf_partial_cnt - pp0, 1);
        check("perf_stall", perf_stall_rs_cnt - ps0, 0);
`endif
        mdu_free = 2'd2;

        // Store blocked by full LSU RS holds the younger ADD behind it
        lsu_free = 2'd0;
        load(mk(OPC_STORE, 7'd0, 6'd7), mk(OPC_OP, 7'd0, 6'd8));
        for (int c = 0; c < 3; c++) begin
            check("s3_stall_rob_we", 32'(rob_we), 0);
            check("s3_stall_rdy", 32'(dispatch_rdy), 0);
            tick();
        end
        lsu_free = 2'd1; #1;
        check("s3_rob_we", 32'(rob_we), 2'b11);
        check("s3_lsu_we", 32'(lsu_we), 2'b01);
        check("s3_alu_we", 32'(alu_we), 2'b01);
        check("s3_alu_tag", 32'(alu_inst0.dest_tag), 8);
        check("s3_rdy", 32'(dispatch_rdy), 1);
        tick();
        lsu_free = 2'd2;

        // Two ALU ops with one ALU slot: partial drain
        alu_free = 2'd1;
        load(mk(OPC_OP, 7'd0, 6'd1), mk(OPC_OP, 7'd0, 6'd2));
        check("s4a_rob_we", 32'(rob_we), 2'b01);
        check("s4a_alu_we", 32'(alu_we), 2'b01);
        check("s4a_rdy", 32'(dispatch_rdy), 0);
        tick();
        check("s4b_rob_we", 32'(rob_we), 2'b01);
        check("s4b_alu_we", 32'(alu_we), 2'b01);
        check("s4b_alu_tag", 32'(alu_inst0.dest_tag), 2);
        tick();
        alu_free = 2'd2;

        // SUB (funct7=0100000) is ALU: same-class pair uses ports 0 and 1
        load(mk(OPC_OP, 7'b0100000, 6'd20), mk(OPC_OP, 7'd0, 6'd21));
        check("s5_alu_we", 32'(alu_we), 2'b11);
        check("s5_mdu_we", 32'(mdu_we), 2'b00);
        check("s5_alu1_tag", 32'(alu_inst1.dest_tag), 21);
        tick();

        // Flush a stalled pair, then reload
        lsu_free = 2'd0;
        load(mk(OPC_STORE, 7'd0, 6'd9), mk(OPC_OP, 7'd0, 6'd10));
        check("s6_stalled", 32'(rob_we), 0);
        flush = 1'b1; #1;
        check("s6_flush_rdy", 32'(dispatch_rdy), 0);
        check("s6_flush_we", 32'(rob_we), 0);
        tick();
        flush = 1'b0; lsu_free = 2'd2; #1;
        check("s6_post_we", 32'(rob_we), 0);
        check("s6_post_rdy", 32'(dispatch_rdy), 1);
        load(mk(OPC_OP, F7_MULDIV, 6'd11), mk(OPC_LOAD, 7'd0, 6'd12));
        check("s6_reload_rob", 32'(rob_we), 2'b11);
        check("s6_reload_mdu", 32'(mdu_we), 2'b01);
        check("s6_reload_lsu", 32'(lsu_we), 2'b01);
        tick();

        // Flush coincident with a load: flush wins
        flush = 1'b1;
        load(mk(OPC_OP, 7'd0, 6'd13), mk(OPC_OP, 7'd0, 6'd14));
        flush = 1'b0; #1;
        check("s7_flush_load_we", 32'(rob_we), 0);
        check("s7_flush_load_rdy", 32'(dispatch_rdy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
